// File: rtl/qtable_gen.sv
// qtable_gen: runtime quantiser-table generator.
// For every coefficient it reads a base Q from an external ROM, scales it by a
// quality percentage, clamps it, and produces 1/Q as {mantissa, exponent}.
// One restoring divider is shared by the /100 scaling step and the reciprocal.
// Optional build macro: QTABLE_GEN_ZIGZAG_EN selects zigzag fetch order.
module qtable_gen #(
  parameter int NUM_COEF = 128,
  parameter int ADDR_W   = 7,
  parameter int Q_W      = 8,
  parameter int SCALE_W  = 8,
  parameter int MANT_W   = 16,
  parameter int EXP_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SCALE_W-1:0] scale,
  output logic               busy,
  output logic               done,
  output logic               rom_rd,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [Q_W-1:0]     rom_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_idx,
  output logic [Q_W-1:0]     out_q,
  output logic [MANT_W-1:0]  out_mant,
  output logic [EXP_W-1:0]   out_exp
);

  // Divider sizing: scaling divide runs D steps, reciprocal runs RD steps.
  localparam int D    = Q_W + SCALE_W + 1;
  localparam int RD   = MANT_W + 1;
  localparam int DV_W = (D > RD) ? D : RD;
  localparam int RW   = (Q_W > 7) ? Q_W : 7;   // holds divisor 100 or q
  localparam int CW   = $clog2(DV_W + 1);
  localparam int SW   = $clog2(Q_W + 1);
  localparam int NW   = MANT_W + Q_W;          // width of 2**(MANT_W-1+s)

  localparam logic [DV_W-1:0]   QMAX_W    = DV_W'((1 << Q_W) - 1);
  localparam logic [MANT_W:0]   MANT_OVF  = (MANT_W+1)'(2 ** (MANT_W - 1));
  localparam logic [MANT_W-1:0] MANT_HALF = MANT_W'(2 ** (MANT_W - 2));
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_COEF - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT, S_SCALE, S_DIV,
    S_NORM, S_RECIP, S_ROUND, S_OUT, S_DONE
  } state_e;

`ifdef QTABLE_GEN_ZIGZAG_EN
  // Standard JPEG zigzag: scan position -> raster position within an 8x8 block.
  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  function automatic logic [ADDR_W-1:0] fetch_addr(input logic [ADDR_W-1:0] j);
    logic [ADDR_W-1:0] a;
    a      = j;
    a[5:0] = ZZ[j[5:0]];
    return a;
  endfunction
`else
  function automatic logic [ADDR_W-1:0] fetch_addr(input logic [ADDR_W-1:0] j);
    return j;
  endfunction
`endif

  // Smallest s with 2**s >= v (v >= 1).
  function automatic logic [SW-1:0] ceil_log2(input logic [Q_W-1:0] v);
    logic [Q_W:0]  pow;
    logic [SW-1:0] r;
    r = '0;
    for (int i = Q_W; i >= 0; i--) begin
      pow = (Q_W+1)'(1) << i;
      if (pow >= {1'b0, v}) r = SW'(i);
    end
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [SCALE_W-1:0]  scale_q, scale_d;
  logic [Q_W-1:0]      base_q, base_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DV_W-1:0]     dvd_q, dvd_d;     // dividend bits, shifted out MSB first
  logic [DV_W-1:0]     quo_q, quo_d;     // quotient bits, shifted in at LSB
  logic [RW-1:0]       rem_q, rem_d;
  logic [RW-1:0]       dvs_q, dvs_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [Q_W-1:0]      q_q, q_d;
  logic [SW-1:0]       s_q, s_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
  logic [Q_W-1:0]      out_q_q, out_q_d;
  logic [MANT_W-1:0]   out_mant_q, out_mant_d;
  logic [EXP_W-1:0]    out_exp_q, out_exp_d;
  logic                busy_q, done_q, rom_rd_q;

  logic [D-1:0]        prod;
  logic [RW:0]         trial, diff;
  logic                fits;
  logic [RW-1:0]       rem_step;
  logic [Q_W-1:0]      q_clamp;
  logic [SW-1:0]       s_calc;
  logic [NW-1:0]       recip_n;
  logic [MANT_W:0]     mant_sum;
  logic [EXP_W-1:0]    exp_calc;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath next values.
  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    scale_d     = scale_q;
    base_d      = base_q;
    idx_d       = idx_q;
    dvd_d       = dvd_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    s_d         = s_q;
    rom_addr_d  = rom_addr_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_q_d     = out_q_q;
    out_mant_d  = out_mant_q;
    out_exp_d   = out_exp_q;

    // Shared arithmetic, evaluated every cycle and used by the states below.
    prod     = D'(base_q) * D'(scale_q) + D'(50);
    trial    = {rem_q, dvd_q[DV_W-1]};
    diff     = trial - {1'b0, dvs_q};
    fits     = (trial >= {1'b0, dvs_q});
    rem_step = fits ? diff[RW-1:0] : trial[RW-1:0];

    if (quo_q == '0)          q_clamp = Q_W'(1);
    else if (quo_q > QMAX_W)  q_clamp = '1;
    else                      q_clamp = quo_q[Q_W-1:0];
    s_calc  = ceil_log2(q_clamp);
    recip_n = NW'(1) << (MANT_W - 1 + int'(s_calc));

    mant_sum = (MANT_W+1)'(quo_q[MANT_W:1]) + (MANT_W+1)'(quo_q[0]);
    exp_calc = EXP_W'(1) - EXP_W'(s_q);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          scale_d    = scale;
          idx_d      = '0;
          rom_addr_d = fetch_addr('0);
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        base_d  = rom_data;
        state_d = S_SCALE;
      end
      S_SCALE: begin
        dvd_d   = DV_W'(prod) << (DV_W - D);
        quo_d   = '0;
        rem_d   = '0;
        dvs_d   = RW'(100);
        cnt_d   = CW'(D);
        state_d = S_DIV;
      end
      S_DIV, S_RECIP: begin
        rem_d = rem_step;
        quo_d = {quo_q[DV_W-2:0], fits};
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = (state_q == S_DIV) ? S_NORM : S_ROUND;
      end
      S_NORM: begin
        // Upper bits of 2**(MANT_W-1+s) preload the remainder; they are < q,
        // so the quotient fits in RD bits.
        q_d     = q_clamp;
        s_d     = s_calc;
        rem_d   = RW'(recip_n >> RD);
        dvd_d   = DV_W'(recip_n[RD-1:0]) << (DV_W - RD);
        quo_d   = '0;
        dvs_d   = RW'(q_clamp);
        cnt_d   = CW'(RD);
        state_d = S_RECIP;
      end
      S_ROUND: begin
        if (mant_sum == MANT_OVF) begin
          out_mant_d = MANT_HALF;
          out_exp_d  = exp_calc + EXP_W'(1);
        end else begin
          out_mant_d = mant_sum[MANT_W-1:0];
          out_exp_d  = exp_calc;
        end
        out_q_d     = q_q;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d      = idx_q + ADDR_W'(1);
            rom_addr_d = fetch_addr(idx_q + ADDR_W'(1));
            state_d    = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output registers; status outputs decode the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scale_q     <= '0;
      base_q      <= '0;
      idx_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      q_q         <= '0;
      s_q         <= '0;
      rom_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_q_q     <= '0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rom_rd_q    <= 1'b0;
    end else begin
      scale_q     <= scale_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      dvd_q       <= dvd_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      s_q         <= s_d;
      rom_addr_q  <= rom_addr_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_q_q     <= out_q_d;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      rom_rd_q    <= (state_d == S_FETCH);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rom_rd    = rom_rd_q;
  assign rom_addr  = rom_addr_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_q     = out_q_q;
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;

endmodule
